// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the iteration-counter width helper.
package DividerPkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold the value N itself, hence N+1 distinct codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract via complement-add, keep the difference only when it is non-negative.
module DivStep
    import DividerPkg::*;
#(
    parameter int N = 8
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N:0]   shifted;
    logic [N+1:0] sum;

    always_comb begin
        shifted = {rem_in[N-1:0], bit_in};
        // Carry-out of shifted + ~divisor + 1 is set exactly when shifted >= divisor.
        sum     = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + (N + 2)'(1);
        q_bit   = sum[N+1];
        rem_out = q_bit ? sum[N:0] : shifted;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_EARLY_ZERO_EN: a zero divisor finishes in one cycle.
module seq_divider
    import DividerPkg::*;
#(
    parameter int INPUT_BIT_WIDTH = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic [INPUT_BIT_WIDTH-1:0] Dividend,
    input  logic [INPUT_BIT_WIDTH-1:0] Divisor,
    output logic                       Busy,
    output logic                       Done,
    output logic [INPUT_BIT_WIDTH-1:0] Quotient,
    output logic [INPUT_BIT_WIDTH-1:0] Remainder,
    output logic                       DivByZero
);

    localparam int N  = INPUT_BIT_WIDTH;
    localparam int CW = cnt_width(N);

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N:0]     rem_q, rem_d;
    logic [N-1:0]   dvd_q, dvd_d;     // dividend bits shift out, quotient bits shift in
    logic [N-1:0]   dsr_q, dsr_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rmd_q, rmd_d;
    logic           dbz_q, dbz_d;

    logic [N:0]     step_rem;
    logic           step_bit;

    DivStep #(.N(N)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[N-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
`ifdef SEQ_DIVIDER_EARLY_ZERO_EN
                    if (Divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rmd_d   = Dividend;
                        dbz_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d = RUN;
                        count_d = CW'(N);
                        rem_d   = '0;
                        dvd_d   = Dividend;
                        dsr_d   = Divisor;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[N-2:0], step_bit};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = {dvd_q[N-2:0], step_bit};
                    rmd_d   = step_rem[N-1:0];
                    dbz_d   = (dsr_q == '0);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Busy      = (state_q == RUN);
    assign Done      = (state_q == DONE);
    assign Quotient  = quo_q;
    assign Remainder = rmd_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: expected results and completion cycles
// are queued at each accepted Start and compared whenever Done pulses.
module tb_seq_divider;

    localparam int N = 8;
`ifdef SEQ_DIVIDER_EARLY_ZERO_EN
    localparam bit EARLY_ZERO = 1'b1;
`else
    localparam bit EARLY_ZERO = 1'b0;
`endif

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [N-1:0] Dividend;
    logic [N-1:0] Divisor;
    logic         Busy;
    logic         Done;
    logic [N-1:0] Quotient;
    logic [N-1:0] Remainder;
    logic         DivByZero;

    seq_divider #(.INPUT_BIT_WIDTH(N)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivByZero (DivByZero)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           done_cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [N-1:0] last_q = '0;
    logic [N-1:0] last_r = '0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // drive_cyc is the cycle index seen at the negedge before the accepting edge.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int drive_cyc);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        e.done_cyc = drive_cyc + 1 + ((EARLY_ZERO && b == '0) ? 0 : N);
        return e;
    endfunction

    always @(negedge Clock) begin
        if (!Reset) begin
            check("busy_done_excl", {31'd0, Busy & Done}, 0);
            if (Done) begin
                check("done_expected", (sb.size() != 0) ? 1 : 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("quotient",  Quotient,  mon_e.q);
                    check("remainder", Remainder, mon_e.r);
                    check("divbyzero", DivByZero, mon_e.dbz);
                    check("done_cycle", cyc, mon_e.done_cyc);
                    last_q = mon_e.q;
                    last_r = mon_e.r;
                end
            end
        end
    end

    // Returns at the negedge of the first cycle after the accepting edge.
    task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge Clock);
        Start    = 1'b1;
        Dividend = a;
        Divisor  = b;
        sb.push_back(model(a, b, cyc));
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge Clock);
        check("q_hold", Quotient,  last_q);
        check("r_hold", Remainder, last_r);
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        #1;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_q",    Quotient, 0);
        check("rst_r",    Remainder, 0);
        check("rst_dbz",  DivByZero, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // 100/7 with explicit Busy window
        drive_start(8'd100, 8'd7);
        for (int i = 0; i < N; i++) begin
            check("busy_window", Busy, 1);
            check("no_early_done", Done, 0);
            @(negedge Clock);
        end
        check("done_pulse", Done, 1);
        check("busy_in_done", Busy, 0);
        wait_done();

        drive_start(8'd255, 8'd1);
        wait_done();
        drive_start(8'd5, 8'd9);
        wait_done();

        // Zero divisor; latency depends on build option
        drive_start(8'd37, 8'd0);
        wait_done();

        // Start pulsed mid-RUN must be ignored
        drive_start(8'd200, 8'd3);
        repeat (3) @(negedge Clock);
        Start    = 1'b1;
        Dividend = 8'd50;
        Divisor  = 8'd5;
        @(negedge Clock);
        Start = 1'b0;
        wait_done();

        // Start held through the Done cycle: back-to-back acceptance
        @(negedge Clock);
        Start    = 1'b1;
        Dividend = 8'd123;
        Divisor  = 8'd10;
        sb.push_back(model(8'd123, 8'd10, cyc));
        @(negedge Clock);
        Dividend = 8'd81;
        Divisor  = 8'd9;
        repeat (N) @(negedge Clock);
        sb.push_back(model(8'd81, 8'd9, cyc));
        @(negedge Clock);
        Start = 1'b0;
        wait_done();

        // Reset mid-RUN discards the operation
        drive_start(8'd200, 8'd3);
        repeat (4) @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_done", Done, 0);
        check("mid_rst_q",    Quotient, 0);
        check("mid_rst_r",    Remainder, 0);
        check("mid_rst_dbz",  DivByZero, 0);
        sb.delete();
        @(negedge Clock);
        Reset = 1'b0;
        drive_start(8'd10, 8'd3);
        wait_done();

        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom_range(0, 255));
            b = (k == 5) ? '0 : N'($urandom_range(1, 255));
            drive_start(a, b);
            wait_done();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
